cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The module SHALL have no parameters; all widths SHALL come from the shared lc3b_types package (lc3b_word 16 b, lc3b_line 128 b).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 icache_pmem_read  input  1  I-cache line read request; held high until icache_pmem_resp.
REQ-005 icache_pmem_write  input  1  I-cache line write request; held high until icache_pmem_resp.
REQ-006 icache_pmem_address  input  lc3b_word  I-cache line address.
REQ-007 icache_pmem_wdata  input  lc3b_line  I-cache write line.
REQ-008 icache_pmem_resp  output  1  one-cycle completion to the I-cache.
REQ-009 icache_pmem_rdata  output  lc3b_line  read line to the I-cache.
REQ-010 dcache_pmem_read / _write / _address / _wdata / _resp / _rdata SHALL mirror REQ-004..009 for the D-cache.
REQ-011 pmem_read, pmem_write  output  1 each  physical-memory command.
REQ-012 pmem_address  output  lc3b_word; pmem_wdata  output  lc3b_line  physical-memory address and write line.
REQ-013 pmem_resp  input  1; pmem_rdata  input  lc3b_line  physical-memory completion and read line.

Function
REQ-014 FSM states SHALL be IDLE, GRANT_I, GRANT_D.
REQ-015 In IDLE, req_i = icache_pmem_read|icache_pmem_write and req_d likewise; no request -> stay IDLE.
REQ-016 Only one requester -> next state SHALL be its GRANT state.
REQ-017 Both requesting in the same cycle -> grant the requester not granted last (round-robin via a 1-bit last_grant register, updated on every grant).
REQ-018 On the IDLE->GRANT edge, the arbiter SHALL latch the winner's address, wdata and op into internal registers; op = write if write is high, else read (write wins if both are high).
REQ-019 In GRANT_x, pmem_address/pmem_wdata SHALL come from the latched registers, and exactly one of pmem_read/pmem_write SHALL be high per the latched op.
REQ-020 In GRANT_x, the granted requester's resp SHALL equal pmem_resp combinationally in the same cycle; the other requester's resp SHALL stay 0.
REQ-021 Both icache_pmem_rdata and dcache_pmem_rdata SHALL always equal pmem_rdata; validity is qualified by resp only.
REQ-022 GRANT_x with pmem_resp=1 -> next state IDLE; otherwise remain in GRANT_x (no timeout).
REQ-023 In IDLE, pmem_read, pmem_write and both resp outputs SHALL be 0; pmem_address/pmem_wdata SHALL hold the latched values.
REQ-024 Latency: a request seen in IDLE at cycle 0 SHALL drive pmem_* from cycle 1; after completion at cycle N, the next grant SHALL be decided at cycle N+1 (minimum one IDLE cycle between transactions).
REQ-025 Requester inputs changing during its grant SHALL NOT affect pmem_* (latched values are used).
REQ-026 A requester that is losing arbitration SHALL remain pending; round-robin SHALL bound its wait to one competing transaction.

Reset
REQ-027 With rst_n=0 at a clock edge, state SHALL become IDLE, last_grant SHALL become I-cache (so the first tie goes to the D-cache), and latched address/wdata SHALL be 0.
REQ-028 Reset during GRANT_x SHALL abort the transaction: from the next cycle pmem_read/pmem_write and both resp outputs SHALL be 0, and no resp SHALL be delivered for the aborted request.

Structure
REQ-029 The arbiter state enum SHALL be defined in lc3b_types alongside lc3b_word and lc3b_line.
REQ-030 The module SHALL be flat: FSM, last_grant and latch registers in one module, with no sub-modules.
REQ-031 The arbiter SHALL be instantiated between the split I/D caches and physical memory in the top level.

Verification
REQ-032 I-cache read only, address 0x1230, pmem_resp after 3 cycles -> pmem_read high cycles 1-3 with address 0x1230, icache_pmem_resp high in cycle 3 only, dcache_pmem_resp stays 0.
REQ-033 Both read in cycle 0 after reset -> D-cache granted first; after its resp, one IDLE cycle, then I-cache granted.
REQ-034 Both continuously requesting for 4 transactions -> grants strictly alternate D, I, D, I.
REQ-035 D-cache write, address 0x4000, wdata 0xA5 pattern, with dcache_pmem_address changed to 0xFFFF mid-grant -> pmem_write high, pmem_address stays 0x4000, pmem_wdata unchanged.
REQ-036 rst_n=0 in cycle 2 of a GRANT_I read -> cycle 3: pmem_read=0, icache_pmem_resp never pulses, state IDLE.
REQ-037 I-cache read and write both asserted -> pmem_write=1, pmem_read=0 for the whole grant.

Source files
------------

// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b data widths plus the enums used by the memory-side arbiter
// that sits between the split I/D caches and physical memory.
//   lc3b_word   : 16-bit address / data word
//   lc3b_line   : 128-bit cache line
//   arb_state_t : arbiter FSM state
//   arb_src_t   : requester identity (I-cache or D-cache)
//   arb_op_t    : memory operation carried by a grant
// ----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Winner selection, meaningful only when at least one requester is active.
  // On a tie the requester that was not granted last wins.
  function automatic arb_src_t arb_pick(input logic     req_i,
                                        input logic     req_d,
                                        input arb_src_t last);
    if (req_i && req_d)
      return (last == SRC_I) ? SRC_D : SRC_I;
    else if (req_d)
      return SRC_D;
    else
      return SRC_I;
  endfunction

  // A requester raising both read and write is treated as a write.
  function automatic arb_op_t arb_op(input logic rd, input logic wr);
    if (wr)
      return OP_WRITE;
    else if (rd)
      return OP_READ;
    else
      return OP_READ;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
// Round-robin arbiter that shares one physical-memory port between the
// I-cache and D-cache. The winner's address, write line and operation are
// latched when the grant is taken, so requester-side changes during a grant
// never reach physical memory.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no transaction; arbitrate pending requests, command lines low
//   GRANT_I | I-cache owns pmem until pmem_resp, resp routed to I-cache
//   GRANT_D | D-cache owns pmem until pmem_resp, resp routed to D-cache
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   icache_pmem_* (read/write/address/wdata in, resp/rdata out)
//   dcache_pmem_* (read/write/address/wdata in, resp/rdata out)
//   pmem_read/write/address/wdata (out), pmem_resp/rdata (in)
// ----------------------------------------------------------------------------
module cache_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,

  input  logic     icache_pmem_read,
  input  logic     icache_pmem_write,
  input  lc3b_word icache_pmem_address,
  input  lc3b_line icache_pmem_wdata,
  output logic     icache_pmem_resp,
  output lc3b_line icache_pmem_rdata,

  input  logic     dcache_pmem_read,
  input  logic     dcache_pmem_write,
  input  lc3b_word dcache_pmem_address,
  input  lc3b_line dcache_pmem_wdata,
  output logic     dcache_pmem_resp,
  output lc3b_line dcache_pmem_rdata,

  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  logic     pmem_resp,
  input  lc3b_line pmem_rdata
);

  arb_state_t state;
  arb_src_t   last_grant;
  lc3b_word   addr_q;
  lc3b_line   wdata_q;
  logic       rd_q;
  logic       wr_q;

  logic       req_i;
  logic       req_d;
  arb_src_t   winner;
  arb_op_t    win_op;
  lc3b_word   win_addr;
  lc3b_line   win_wdata;

  assign req_i = icache_pmem_read | icache_pmem_write;
  assign req_d = dcache_pmem_read | dcache_pmem_write;

  assign winner = arb_pick(req_i, req_d, last_grant);

  always_comb begin
    win_op    = OP_READ;
    win_addr  = icache_pmem_address;
    win_wdata = icache_pmem_wdata;
    if (winner == SRC_D) begin
      win_op    = arb_op(dcache_pmem_read, dcache_pmem_write);
      win_addr  = dcache_pmem_address;
      win_wdata = dcache_pmem_wdata;
    end else begin
      win_op    = arb_op(icache_pmem_read, icache_pmem_write);
    end
  end

  // Command lines are registered alongside the state so they are clean for
  // the whole grant and drop in the same cycle the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SRC_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            state      <= (winner == SRC_D) ? GRANT_D : GRANT_I;
            last_grant <= winner;
            addr_q     <= win_addr;
            wdata_q    <= win_wdata;
            rd_q       <= (win_op == OP_READ);
            wr_q       <= (win_op == OP_WRITE);
          end
        end
        GRANT_I, GRANT_D: begin
          if (pmem_resp) begin
            state <= IDLE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is forwarded in the same cycle memory reports it, but only to
  // the current owner.
  assign icache_pmem_resp = (state == GRANT_I) && pmem_resp;
  assign dcache_pmem_resp = (state == GRANT_D) && pmem_resp;

  // Read data is broadcast; resp is the only validity qualifier.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule
